// File: rtl/amba_axi_pkg.sv
// rtl/amba_axi_pkg.sv - shared AXI3 write-master codes, defaults and FSM state type
package amba_axi_pkg;

  // B channel response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AW burst type codes
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // fixed attributes for decoder output traffic: bufferable, non-secure data
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0001;
  localparam logic [2:0] AWPROT_DEFAULT  = 3'b010;
  localparam logic [1:0] AWLOCK_NORMAL   = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } wr_state_t;

  // AxSIZE encoding for a beat of the given byte width
  function automatic logic [2:0] size_code(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_wr_fifo.sv
// rtl/axi_wr_fifo.sv - show-ahead data FIFO feeding the W channel
module axi_wr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  // a pop frees a slot in the same cycle, so a full FIFO may still take a push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // storage is not reset; occupancy alone decides which entries are valid
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointer and occupancy tracking; reset flushes all entries
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/amba_axi_burst_write.sv
// rtl/amba_axi_burst_write.sv - AXI3 INCR burst write master; AXI_WR_ERR_EN enables slave error capture
module amba_axi_burst_write
  import amba_axi_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [3:0]  AXI_ID     = 4'h0,
  parameter int          MAX_BURST  = 16,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [31:0]         cmd_addr,
  input  logic [3:0]          cmd_len,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   dat_data,
  input  logic                dat_valid,
  output logic                dat_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         err_addr,
  input  logic                err_clr,
  output logic [3:0]          awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [3:0] MAX_LEN = 4'(MAX_BURST - 1);

  wr_state_t         state;
  logic [31:0]       addr_q;
  logic [3:0]        len_q;
  logic [4:0]        beats_left;
  logic              aw_done;
  logic              awvalid_q;
  logic              bready_q;
  logic              done_q;
  logic [3:0]        len_sat;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              aw_hs;
  logic              w_hs;
  logic              b_match;
  logic              w_complete;
  logic              aw_complete;

  assign len_sat     = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign aw_hs       = awvalid_q && awready;
  assign w_hs        = wvalid && wready;
  assign b_match     = bready_q && bvalid && (bid == AXI_ID);
  // last beat already gone, or going this cycle; AW likewise
  assign w_complete  = (beats_left == 5'd0) || (w_hs && wlast);
  assign aw_complete = aw_done || aw_hs;

  axi_wr_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (dat_valid && dat_ready),
    .push_data (dat_data),
    .pop       (w_hs),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // burst sequencing: command latch, AW/W progress tracking, B acceptance
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beats_left <= '0;
      aw_done    <= 1'b0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            len_q      <= len_sat;
            beats_left <= {1'b0, len_sat} + 5'd1;
            awvalid_q  <= 1'b1;
            aw_done    <= 1'b0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) beats_left <= beats_left - 5'd1;
          if (w_complete && aw_complete) begin
            bready_q <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          // responses tagged for another master are left alone
          if (b_match) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dat_ready = !fifo_full;
  assign done      = done_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_code(DATA_W / 8);
  assign awburst = BURST_INCR;
  assign awlock  = AWLOCK_NORMAL;
  assign awcache = AWCACHE_DEFAULT;
  assign awprot  = AWPROT_DEFAULT;
  assign awvalid = awvalid_q;

  assign wid    = AXI_ID;
  assign wvalid = (state == BURST) && !fifo_empty && (beats_left != 5'd0);
  // stale storage is hidden so an empty FIFO presents zero data
  assign wdata  = fifo_empty ? '0 : fifo_head;
  assign wstrb  = '1;
  assign wlast  = (beats_left == 5'd1);
  assign bready = bready_q;

`ifdef AXI_WR_ERR_EN
  logic        err_q;
  logic [31:0] err_addr_q;
  logic        b_err;

  assign b_err = b_match && (bresp != RESP_OKAY);

  // sticky error with first-failure address; a new error outranks a same-cycle clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (b_err) begin
      err_q <= 1'b1;
      if (!err_q) err_addr_q <= addr_q;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = &{1'b0, err_clr, bresp};
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_amba_axi_burst_write.sv
// tb/tb_amba_axi_burst_write.sv - directed self-checking bench for amba_axi_burst_write
module tb_amba_axi_burst_write;

`ifdef AXI_WR_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // shared stimulus
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        cmd_valid = 1'b0, s_cmd_valid = 1'b0;
  logic [31:0] dat_data = '0;
  logic        dat_valid = 1'b0, s_dat_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        awready = 1'b1;
  logic        wready;
  logic        wr_mode = 1'b0, wr_fix = 1'b1, wr_tog = 1'b0;
  logic [3:0]  bid = '0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;

  // main DUT outputs
  logic        cmd_ready, dat_ready, busy, done, err, awvalid, wlast, wvalid, bready;
  logic [31:0] err_addr, awaddr, wdata;
  logic [3:0]  awid, awlen, awcache, wid, wstrb;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;

  // saturating DUT outputs
  logic        s_cmd_ready, s_dat_ready, s_busy, s_done, s_err, s_awvalid, s_wlast, s_wvalid, s_bready;
  logic [31:0] s_err_addr, s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_awlen, s_awcache, s_wid, s_wstrb;
  logic [2:0]  s_awsize, s_awprot;
  logic [1:0]  s_awburst, s_awlock;

  amba_axi_burst_write #(.DATA_W(32), .AXI_ID(4'h0), .MAX_BURST(16), .FIFO_DEPTH(16)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .dat_data(dat_data), .dat_valid(dat_valid),
    .dat_ready(dat_ready), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .err_clr(err_clr), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  amba_axi_burst_write #(.DATA_W(32), .AXI_ID(4'h0), .MAX_BURST(4), .FIFO_DEPTH(16)) u_sat (
    .aclk(aclk), .aresetn(aresetn), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .dat_data(dat_data), .dat_valid(s_dat_valid),
    .dat_ready(s_dat_ready), .busy(s_busy), .done(s_done), .err(s_err), .err_addr(s_err_addr),
    .err_clr(err_clr), .awid(s_awid), .awaddr(s_awaddr), .awlen(s_awlen), .awsize(s_awsize),
    .awburst(s_awburst), .awlock(s_awlock), .awcache(s_awcache), .awprot(s_awprot),
    .awvalid(s_awvalid), .awready(awready), .wid(s_wid), .wdata(s_wdata), .wstrb(s_wstrb),
    .wlast(s_wlast), .wvalid(s_wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(s_bready)
  );

  assign wready = wr_mode ? wr_tog : wr_fix;

  // toggling wready pattern, changes just after each rising edge
  always @(posedge aclk) wr_tog <= ~wr_tog;

  // W/AW handshake recorder for the main DUT, sampled mid-cycle
  logic [31:0] wq[$];
  logic        lq[$];
  int          aw_count = 0;
  always @(negedge aclk) begin
    if (aresetn && wvalid && wready) begin
      wq.push_back(wdata);
      lq.push_back(wlast);
    end
    if (aresetn && awvalid && awready) aw_count++;
  end

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic push(input logic [31:0] d);
    dat_data = d; dat_valid = 1'b1;
    step();
    dat_valid = 1'b0;
  endtask

  task automatic s_push(input logic [31:0] d);
    dat_data = d; s_dat_valid = 1'b1;
    step();
    s_dat_valid = 1'b0;
  endtask

  task automatic cmd(input logic [31:0] a, input logic [3:0] l);
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic s_cmd(input logic [31:0] a, input logic [3:0] l);
    cmd_addr = a; cmd_len = l; s_cmd_valid = 1'b1;
    step();
    s_cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [3:0] id, input logic [1:0] r);
    bid = id; bresp = r; bvalid = 1'b1;
    step();
    bvalid = 1'b0; bid = '0; bresp = '0;
  endtask

  task automatic wait_bready(input string tag);
    for (int i = 0; i < 100 && !bready; i++) step();
    check(tag, bready, 1);
  endtask

  // run saturating-DUT beats until bready, checking data against a base value
  task automatic s_run(input string tag, input logic [31:0] base, output int nb);
    nb = 0;
    for (int c = 0; c < 30 && !s_bready; c++) begin
      if (s_wvalid) begin
        check(tag, s_wdata, base + 32'(nb));
        nb++;
      end
      step();
    end
  endtask

  int base;
  int aw0;
  int nb;

  initial begin
    // reset state
    repeat (3) @(posedge aclk);
    #2;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_awlen", awlen, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_dat_ready", dat_ready, 1);
    aresetn = 1'b1;
    step();

    // single beat
    base = wq.size();
    push(32'hCAFEBABE);
    cmd(32'h1000, 4'd0);
    check("t1_awvalid", awvalid, 1);
    check("t1_awaddr", awaddr, 32'h1000);
    check("t1_awlen", awlen, 0);
    check("t1_wvalid", wvalid, 1);
    check("t1_wlast", wlast, 1);
    check("t1_wdata", wdata, 32'hCAFEBABE);
    check("t1_busy", busy, 1);
    check("t1_cmd_ready", cmd_ready, 0);
    check("t1_awsize", awsize, 3'd2);
    check("t1_awburst", awburst, 2'b01);
    check("t1_awcache", awcache, 4'b0001);
    check("t1_awprot", awprot, 3'b010);
    check("t1_awlock", awlock, 2'b00);
    check("t1_wstrb", wstrb, 4'hF);
    check("t1_ids", {awid, wid}, 8'h00);
    step();
    check("t1_bready", bready, 1);
    check("t1_awvalid_low", awvalid, 0);
    check("t1_wvalid_low", wvalid, 0);
    check("t1_beats", wq.size() - base, 1);
    check("t1_done_early", done, 0);
    respond(4'h0, 2'b00);
    check("t1_done", done, 1);
    check("t1_bready_low", bready, 0);
    check("t1_busy_low", busy, 0);
    step();
    check("t1_done_pulse", done, 0);

    // full burst with toggling wready
    wr_mode = 1'b1;
    base = wq.size();
    for (int i = 0; i < 16; i++) push(32'(i));
    check("t2_full", dat_ready, 0);
    cmd(32'h2000, 4'd15);
    check("t2_awaddr", awaddr, 32'h2000);
    check("t2_awlen", awlen, 15);
    wait_bready("t2_bready_timeout");
    check("t2_beats", wq.size() - base, 16);
    for (int i = 0; i < 16 && base + i < wq.size(); i++) begin
      check($sformatf("t2_data%0d", i), wq[base+i], 64'(i));
      check($sformatf("t2_last%0d", i), lq[base+i], (i == 15) ? 64'd1 : 64'd0);
    end
    respond(4'h0, 2'b00);
    check("t2_done", done, 1);
    wr_mode = 1'b0;

    // AW stalled while W runs ahead
    awready = 1'b0;
    base = wq.size();
    aw0 = aw_count;
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    cmd(32'h3000, 4'd3);
    repeat (20) step();
    check("t3_w_first", wq.size() - base, 4);
    check("t3_no_aw", aw_count - aw0, 0);
    check("t3_busy", busy, 1);
    check("t3_bready_wait", bready, 0);
    check("t3_awvalid", awvalid, 1);
    check("t3_wvalid", wvalid, 0);
    awready = 1'b1;
    step();
    check("t3_bready", bready, 1);
    check("t3_awvalid_low", awvalid, 0);
    check("t3_aw_once", aw_count - aw0, 1);
    respond(4'h0, 2'b00);
    check("t3_done", done, 1);

    // length saturation and queued surplus on the MAX_BURST=4 instance
    for (int k = 0; k < 6; k++) s_push(32'h60 + 32'(k));
    s_cmd(32'h4000, 4'd9);
    check("t4_awlen", s_awlen, 3);
    s_run("t4_beat", 32'h60, nb);
    check("t4_nbeats", nb, 4);
    check("t4_bready", s_bready, 1);
    respond(4'h0, 2'b00);
    check("t4_done", s_done, 1);
    s_cmd(32'h4100, 4'd1);
    check("t4b_awlen", s_awlen, 1);
    s_run("t4b_beat", 32'h64, nb);
    check("t4b_nbeats", nb, 2);
    respond(4'h0, 2'b00);
    check("t4b_done", s_done, 1);

    // B filtering and error capture
    push(32'h55);
    cmd(32'h5000, 4'd0);
    wait_bready("t5_bready_timeout");
    respond(4'h5, 2'b11);
    check("t5_ignored_bready", bready, 1);
    check("t5_ignored_done", done, 0);
    check("t5_ignored_err", err, 0);
    respond(4'h0, 2'b10);
    check("t5_done", done, 1);
    check("t5_err", err, ERR_EN);
    check("t5_err_addr", err_addr, ERR_EN ? 32'h5000 : 32'h0);
    step();
    check("t5_err_sticky", err, ERR_EN);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_err_clr", err, 0);

    // reset in the middle of an 8-beat burst
    base = wq.size();
    for (int i = 0; i < 8; i++) push(32'h70 + 32'(i));
    cmd(32'h6000, 4'd7);
    repeat (3) step();
    check("t6_beats_before", wq.size() - base, 3);
    aresetn = 1'b0;
    #1;
    check("t6_awvalid", awvalid, 0);
    check("t6_wvalid", wvalid, 0);
    check("t6_bready", bready, 0);
    check("t6_done", done, 0);
    check("t6_busy", busy, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_dat_ready", dat_ready, 1);
    check("t6_awaddr", awaddr, 0);
    check("t6_awlen", awlen, 0);
    check("t6_wdata", wdata, 0);
    step();
    aresetn = 1'b1;
    step();
    cmd(32'h7000, 4'd0);
    repeat (3) step();
    check("t6_flushed", wvalid, 0);
    push(32'h77);
    check("t6_new_wvalid", wvalid, 1);
    check("t6_new_wdata", wdata, 32'h77);
    wait_bready("t6_bready_timeout");
    respond(4'h0, 2'b00);
    check("t6_new_done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
